// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard scheduler.
// Holds the hazard FSM state encoding, the EX operand forwarding
// encodings and the register-match helper used by the forwarding unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } pipe_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_ME = 2'b01;   // operand from ME aluout
    localparam logic [1:0] FWD_WB = 2'b10;   // operand from WB data

    // A later stage supplies a source operand when it writes a real GPR
    // (x0 is hard-wired to zero and never forwarded) that the source names.
    function automatic logic rd_hit(input logic       reg_write,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs);
        return reg_write && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage forwarding comparator for one source operand.
// Purely combinational; the youngest producer (ME) wins over WB.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic       me_reg_write,
    input  logic [4:0] me_rd,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    input  logic [4:0] ex_rs,
    output logic [1:0] fwd_sel
);

    // Select the operand source, ME taking priority over WB.
    always_comb begin
        fwd_sel = FWD_RF;
        if (rd_hit(me_reg_write, me_rd, ex_rs)) begin
            fwd_sel = FWD_ME;
        end else if (rd_hit(wb_reg_write, wb_rd, ex_rs)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard scheduler for the 5-stage pipeline.
// Handles DMEM wait-state freezes (with timeout abort), taken
// branch/jump redirects, load-use stalls and EX operand forwarding.
// Control outputs are combinational from the FSM state and inputs and
// are forced to their safe values while rst_n is low.
// Optional build macro: PIPE_PERF_CNT_EN adds 32-bit performance counters
// (stall_cycles, flush_events, mem_aborts).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        ex_redirect,
    input  logic [4:0]  me_rd,
    input  logic [4:0]  wb_rd,
    input  logic        me_RegWrite,
    input  logic        wb_RegWrite,
    input  logic        me_mem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_me_stall,
    output logic        me_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_me_flush,
    output logic        pc_redirect,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] mem_aborts,
`endif
    output logic        mem_err
);

    // Counter value that, once reached while still waiting, aborts the access.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    pipe_state_t     state_r;
    logic [TO_W-1:0] cnt_r;
    logic            redirect_pending_r;

    logic            frozen_s;
    logic            abort_s;
    logic            redirect_s;
    logic            load_use_s;
    logic [TO_W-1:0] cnt_inc_s;
    logic [1:0]      fwd_a_s;
    logic [1:0]      fwd_b_s;

    assign frozen_s   = ((state_r == RUN) || (state_r == MEM_WAIT)) &&
                        me_mem_req && !dmem_ready;
    assign abort_s    = (state_r == ABORT);
    assign redirect_s = ex_redirect || redirect_pending_r;
    assign load_use_s = ex_is_load && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));
    assign cnt_inc_s  = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};

    pipe_fwd_unit u_fwd_a (
        .me_reg_write (me_RegWrite),
        .me_rd        (me_rd),
        .wb_reg_write (wb_RegWrite),
        .wb_rd        (wb_rd),
        .ex_rs        (ex_rs1),
        .fwd_sel      (fwd_a_s)
    );

    pipe_fwd_unit u_fwd_b (
        .me_reg_write (me_RegWrite),
        .me_rd        (me_rd),
        .wb_reg_write (wb_RegWrite),
        .wb_rd        (wb_rd),
        .ex_rs        (ex_rs2),
        .fwd_sel      (fwd_b_s)
    );

    // Hazard FSM: freeze on DMEM wait, time out into a one-cycle abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                RUN: begin
                    cnt_r <= '0;
                    if (frozen_s) begin
                        state_r <= MEM_WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (frozen_s) begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == TO_LAST) begin
                            state_r <= ABORT;
                        end else begin
                            state_r <= MEM_WAIT;
                        end
                    end else begin
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end
                end
                ABORT: begin
                    cnt_r   <= '0;
                    state_r <= RUN;
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= RUN;
                end
            endcase
        end
    end

    // Remember a redirect resolved while the pipe is held; act on it once free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pending_r <= 1'b0;
        end else if (frozen_s || abort_s) begin
            if (ex_redirect) begin
                redirect_pending_r <= 1'b1;
            end else begin
                redirect_pending_r <= redirect_pending_r;
            end
        end else begin
            redirect_pending_r <= 1'b0;
        end
    end

    // Stall/flush/redirect decode: freeze/abort > redirect > load-use > normal.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        ex_me_stall = 1'b0;
        me_wb_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_me_flush = 1'b0;
        pc_redirect = 1'b0;
        mem_err     = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_me_flush = 1'b1;
        end else begin
            fwd_a = fwd_a_s;
            fwd_b = fwd_b_s;
            if (frozen_s) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                ex_me_stall = 1'b1;
                me_wb_stall = 1'b1;
            end else if (abort_s) begin
                // Drop the faulting access; let the WB stage drain.
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                ex_me_flush = 1'b1;
                mem_err     = 1'b1;
            end else if (redirect_s) begin
                // The ID instruction is discarded, so load-use is moot.
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_s) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_stall    = 1'b0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
            mem_aborts   <= 32'd0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, pc_stall};
            flush_events <= flush_events + {31'd0, pc_redirect};
            mem_aborts   <= mem_aborts + {31'd0, mem_err};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Each cycle the expected output vector is queued when stimulus is driven
// and popped and compared when outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, me_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
    logic        me_RegWrite, wb_RegWrite, me_mem_req, dmem_ready;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall;
    logic        if_id_flush, id_ex_flush, ex_me_flush, pc_redirect, mem_err;
    logic [1:0]  fwd_a, fwd_b;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, mem_aborts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } exp_t;
    exp_t exp_q[$];

    logic [13:0] out_vec;
    assign out_vec = {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall,
                      if_id_flush, id_ex_flush, ex_me_flush, pc_redirect,
                      fwd_a, fwd_b, mem_err};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_redirect(ex_redirect),
        .me_rd(me_rd), .wb_rd(wb_rd),
        .me_RegWrite(me_RegWrite), .wb_RegWrite(wb_RegWrite),
        .me_mem_req(me_mem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_me_stall(ex_me_stall), .me_wb_stall(me_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush),
        .pc_redirect(pc_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_aborts(mem_aborts),
`endif
        .mem_err(mem_err)
    );

    // Expected vector builder: stalls {pc,if_id,id_ex,ex_me,me_wb},
    // flushes {if_id,id_ex,ex_me}, pc_redirect, fwd_a, fwd_b, mem_err.
    function automatic logic [13:0] mk(input logic [4:0] st, input logic [2:0] fl,
                                       input logic rd, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic err);
        return {st, fl, rd, fa, fb, err};
    endfunction

    logic [13:0] E_NORM, E_LU, E_REDIR, E_FRZ, E_ABORT, E_RST;

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [13:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", out_vec, 14'h3fff ^ out_vec);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, out_vec, e.exp);
        end
    endtask

    // Inputs already driven: queue expectation, sample at negedge,
    // then move to just after the next rising edge.
    task automatic step(input string tag, input logic [13:0] exp);
        sb_push(tag, exp);
        @(negedge clk);
        sb_pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_redirect = 1'b0; me_rd = 5'd0; wb_rd = 5'd0;
        me_RegWrite = 1'b0; wb_RegWrite = 1'b0;
        me_mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        E_NORM  = mk(5'b00000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
        E_LU    = mk(5'b11000, 3'b010, 1'b0, 2'b00, 2'b00, 1'b0);
        E_REDIR = mk(5'b00000, 3'b110, 1'b1, 2'b00, 2'b00, 1'b0);
        E_FRZ   = mk(5'b11111, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
        E_ABORT = mk(5'b11100, 3'b001, 1'b0, 2'b00, 2'b00, 1'b1);
        E_RST   = mk(5'b00000, 3'b111, 1'b0, 2'b00, 2'b00, 1'b0);

        // Reset with hazard-provoking inputs: safe values must win.
        rst_n = 1'b0;
        idle();
        me_mem_req = 1'b1; ex_redirect = 1'b1;
        me_RegWrite = 1'b1; me_rd = 5'd3; ex_rs1 = 5'd3;
        #3;
        sb_push("reset_state", E_RST);
        sb_pop_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        step("idle_after_reset", E_NORM);

        // Load-use on rs2, one stall cycle then the bubble moves on.
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        step("load_use_rs2", E_LU);
        ex_is_load = 1'b0;
        step("load_use_bubble", E_NORM);
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step("load_use_x0", E_NORM);
        ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        step("load_use_rs1", E_LU);
        id_use_rs1 = 1'b0;
        step("load_use_not_read", E_NORM);
        idle();

        // Redirect, then redirect masking a load-use match.
        ex_redirect = 1'b1;
        step("redirect", E_REDIR);
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        step("redirect_over_load_use", E_REDIR);
        idle();
        step("after_redirect", E_NORM);

        // DMEM not ready for three cycles, then completes.
        me_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait_freeze", E_FRZ);
        dmem_ready = 1'b1;
        step("mem_wait_release", E_NORM);
        idle();
        step("mem_wait_done", E_NORM);

        // Timeout: four frozen cycles, one abort, redirect captured in abort.
        me_mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("timeout_freeze", E_FRZ);
        ex_redirect = 1'b1;
        step("timeout_abort", E_ABORT);
        idle();
        step("redirect_after_abort", E_REDIR);
        step("after_abort", E_NORM);

        // Redirect pulsed while waiting is held until the freeze lifts.
        me_mem_req = 1'b1;
        step("pend_freeze0", E_FRZ);
        ex_redirect = 1'b1;
        step("pend_freeze1", E_FRZ);
        ex_redirect = 1'b0;
        step("pend_freeze2", E_FRZ);
        dmem_ready = 1'b1;
        step("pend_release", E_REDIR);
        idle();
        step("pend_cleared", E_NORM);

        // Forwarding priority and x0 handling.
        me_rd = 5'd7; wb_rd = 5'd7; me_RegWrite = 1'b1; wb_RegWrite = 1'b1;
        ex_rs1 = 5'd7; ex_rs2 = 5'd3;
        step("fwd_a_me", mk(5'b00000, 3'b000, 1'b0, 2'b01, 2'b00, 1'b0));
        me_RegWrite = 1'b0;
        step("fwd_a_wb", mk(5'b00000, 3'b000, 1'b0, 2'b10, 2'b00, 1'b0));
        me_RegWrite = 1'b1; me_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
        step("fwd_a_x0", E_NORM);
        me_rd = 5'd7; wb_rd = 5'd9; ex_rs1 = 5'd9; ex_rs2 = 5'd7;
        step("fwd_mixed", mk(5'b00000, 3'b000, 1'b0, 2'b10, 2'b01, 1'b0));
        idle();

        // Asynchronous reset in MEM_WAIT, then a full timeout from a clean counter.
        me_mem_req = 1'b1;
        step("rst_freeze0", E_FRZ);
        #2;
        rst_n = 1'b0;
        #1;
        sb_push("async_reset", E_RST);
        sb_pop_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst_freeze", E_FRZ);
        step("post_rst_abort", E_ABORT);
        idle();
        step("post_rst_run", E_NORM);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard scheduler for the 5-stage pipeline (IF/ID, ID/EX, EX/ME, ME/WB registers).
- Detects load-use hazards, taken branches/jumps and data-memory wait states.
- Drives per-register stall/flush controls and the EX-stage forwarding selects.
- Runs a small FSM that freezes the pipeline while DMEM is busy, and aborts after a timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum number of consecutive cycles a DMEM access may stay not-ready before it is aborted; legal range 2..255.
- TO_W, 8, width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_is_load  in  1  EX instruction is a load (WDsel selects memory)
- ex_rs1, ex_rs2  in  5 each  sources of the instruction in EX, used for forwarding
- ex_redirect  in  1  EX resolved a taken branch or jump
- me_rd, wb_rd  in  5 each  destinations in ME and WB
- me_RegWrite, wb_RegWrite  in  1 each  ME/WB instruction writes the GPR
- me_mem_req  in  1  ME instruction accesses DMEM (load or MemWrite)
- dmem_ready  in  1  DMEM completes the access this cycle
- pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush, ex_me_flush  out  1 each  load a bubble
- pc_redirect  out  1  PC takes the EX target this cycle
- fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 01 ME aluout, 10 WB data
- mem_err  out  1  one-cycle pulse when a DMEM timeout abort occurs

Behaviour:
- FSM states: RUN, MEM_WAIT, ABORT. Reset state is RUN; the counter and redirect_pending reset to 0.
- While rst_n is low:
  - all stall outputs, pc_redirect and mem_err are 0;
  - all flush outputs are 1;
  - fwd_a and fwd_b are 00.
- Memory freeze:
  - Condition: state is RUN or MEM_WAIT, me_mem_req=1 and dmem_ready=0.
  - All five stall outputs are 1 and every flush output is 0.
  - Entering from RUN moves the FSM to MEM_WAIT and clears the counter.
  - In MEM_WAIT the counter increments every cycle. When dmem_ready=1 the FSM returns to RUN in the same cycle and no stall is asserted.
  - If the counter reaches MEM_TIMEOUT-1 without dmem_ready, the FSM moves to ABORT.
- ABORT, one cycle:
  - mem_err=1, ex_me_flush=1 (the faulting access is dropped) and me_wb_stall=0.
  - pc_stall, if_id_stall and id_ex_stall are 1.
  - The FSM then returns to RUN.
- Redirect during a freeze: if ex_redirect=1 while frozen or in ABORT, redirect_pending is set. On the first unfrozen cycle the redirect is acted on and redirect_pending clears.
- Redirect (unfrozen, ex_redirect or redirect_pending): pc_redirect=1, if_id_flush=1, id_ex_flush=1. Load-use detection is suppressed because the ID instruction is discarded.
- Load-use, when unfrozen and no redirect:
  - Condition: ex_is_load=1 and ex_rd!=0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1, for exactly one cycle.
- Priority: freeze/ABORT > redirect > load-use > normal.
- Forwarding (combinational):
  - fwd_a=01 when me_RegWrite=1, me_rd!=0 and me_rd==ex_rs1.
  - Otherwise fwd_a=10 when wb_RegWrite=1, wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise fwd_a=00. fwd_b follows the same rules with ex_rs2.
  - ME wins when ME and WB both match.
- Control outputs are combinational from the state and inputs; the only registers are the state, counter and redirect_pending.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits and reset to 0:
  - stall_cycles: counts cycles with pc_stall=1;
  - flush_events: counts cycles with pc_redirect=1;
  - mem_aborts: counts mem_err pulses.
- The counters wrap at 2^32.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state enum: RUN=2'd0, MEM_WAIT=2'd1, ABORT=2'd2;
  - forwarding encodings: FWD_RF, FWD_ME, FWD_WB.
- One natural sub-module: pipe_fwd_unit, the purely combinational forwarding comparator, instantiated once per operand.

Test Plan:
- Load x5 in EX, ID reads x5 as rs2 with id_use_rs2=1 -> exactly one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; then normal flow. Repeat with ex_rd=0 -> no stall.
- ex_redirect=1 with no freeze -> pc_redirect=1, if_id_flush=1, id_ex_flush=1 for 1 cycle. The same cycle also presents a load-use match -> no stall, flush only.
- me_mem_req=1, dmem_ready low for 3 cycles then high -> all five stalls high for 3 cycles, FSM returns to RUN, mem_err stays 0.
- MEM_TIMEOUT=4, dmem_ready held low -> stalls for 4 cycles, then 1 ABORT cycle with mem_err=1 and ex_me_flush=1, then RUN.
- ex_redirect pulsed during MEM_WAIT -> no redirect while frozen; pc_redirect=1 on the cycle after dmem_ready releases.
- me_rd=wb_rd=x7 with both RegWrite=1 and ex_rs1=x7 -> fwd_a=01. Then me_RegWrite=0 -> fwd_a=10. Then both rd=x0 -> fwd_a=00.
- Assert rst_n low while in MEM_WAIT -> flushes=1 and stalls=0 immediately (asynchronously); after release, state is RUN and the counter is 0.
